// File: rtl/phys_reg_free_list_if.sv
`default_nettype none
// ============================================================================
//  Module      : phys_reg_free_list_if
//  Description : Rename-allocate / commit-free bundle for the physical
//                register free list.
//  Revision    : 1.0
// ============================================================================
interface phys_reg_free_list_if #(
    parameter int REG_FILE_ADDR_WIDTH = 7
);
    logic                           alloc_req;
    logic                           alloc_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] alloc_reg;
    logic                           free_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] free_reg;
    logic [REG_FILE_ADDR_WIDTH-1:0] free_count;
    logic                           empty;
    logic                           full;
    logic                           overflow_err;
    logic                           illegal_free;

    modport master (
        output alloc_req, free_valid, free_reg,
        input  alloc_valid, alloc_reg, free_count, empty, full,
               overflow_err, illegal_free
    );

    modport slave (
        input  alloc_req, free_valid, free_reg,
        output alloc_valid, alloc_reg, free_count, empty, full,
               overflow_err, illegal_free
    );
endinterface
`default_nettype wire

// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : phys_reg_free_list
//  Description : Circular FIFO of unallocated physical register indices
//                feeding the rename map table.
//  Revision    : 1.0
// ============================================================================
module phys_reg_free_list #(
    parameter int REG_FILE_ADDR_WIDTH = 7,
    parameter int NUM_PHYS_REGS       = 128,
    parameter int NUM_ARCH_REGS       = 32,
    parameter int FREE_DEPTH          = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
    input  wire logic           clock,
    input  wire logic           reset,
    phys_reg_free_list_if.slave fl
);
    localparam int c_PTR_W = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0]             c_LAST_PTR = c_PTR_W'(FREE_DEPTH - 1);
    localparam logic [REG_FILE_ADDR_WIDTH-1:0] c_DEPTH    = REG_FILE_ADDR_WIDTH'(FREE_DEPTH);

    logic [REG_FILE_ADDR_WIDTH-1:0] r_mem [FREE_DEPTH];
    logic [c_PTR_W-1:0]             r_head;
    logic [c_PTR_W-1:0]             r_tail;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_count;
    logic                           r_overflow;
    logic                           r_illegal;

    logic w_full;
    logic w_pop;
    logic w_idx_zero;
    logic w_idx_in_range;
    logic w_candidate;
    logic w_push;
    logic w_overflow;
    logic w_illegal;

    always_comb begin
        w_full         = (r_count == c_DEPTH);
        w_pop          = fl.alloc_req && (r_count != '0);
        w_idx_zero     = (fl.free_reg == '0);
        w_idx_in_range = (int'(fl.free_reg) < NUM_PHYS_REGS);
        w_candidate    = fl.free_valid && !w_idx_zero && w_idx_in_range;
        // A pop in the same cycle vacates a slot, so a full list can still take the push.
        w_push         = w_candidate && (!w_full || w_pop);
        w_overflow     = w_candidate && w_full && !w_pop;
        w_illegal      = fl.free_valid && !w_idx_in_range;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                r_mem[i] <= REG_FILE_ADDR_WIDTH'(NUM_ARCH_REGS + i);
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= c_DEPTH;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head <= (r_head == c_LAST_PTR) ? '0 : r_head + 1'b1;
            end
            if (w_push) begin
                r_mem[r_tail] <= fl.free_reg;
                r_tail        <= (r_tail == c_LAST_PTR) ? '0 : r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_overflow) r_overflow <= 1'b1;
            if (w_illegal)  r_illegal  <= 1'b1;
        end
    end

    assign fl.alloc_valid  = (r_count != '0);
    assign fl.alloc_reg    = r_mem[r_head];
    assign fl.free_count   = r_count;
    assign fl.empty        = (r_count == '0);
    assign fl.full         = w_full;
    assign fl.overflow_err = r_overflow;
    assign fl.illegal_free = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phys_reg_free_list
//  Description : Self-checking bench for phys_reg_free_list against a
//                queue-based reference model (8-bit index build).
//  Revision    : 1.0
// ============================================================================
module tb_phys_reg_free_list;
    localparam int c_W     = 8;
    localparam int c_PHYS  = 128;
    localparam int c_ARCH  = 32;
    localparam int c_DEPTH = c_PHYS - c_ARCH;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    phys_reg_free_list_if #(.REG_FILE_ADDR_WIDTH(c_W)) ifc ();

    phys_reg_free_list #(
        .REG_FILE_ADDR_WIDTH(c_W),
        .NUM_PHYS_REGS      (c_PHYS),
        .NUM_ARCH_REGS      (c_ARCH),
        .FREE_DEPTH         (c_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fl   (ifc.slave)
    );

    // Reference model: the list is a plain queue of indices, head at [0].
    int m_q[$];
    bit m_ovf;
    bit m_ill;
    bit m_ready = 1'b0;
    bit m_pop;
    bit m_push;
    int m_v;

    always @(posedge clock) begin
        if (!reset) begin
            m_q.delete();
            for (int i = 0; i < c_DEPTH; i++) m_q.push_back(c_ARCH + i);
            m_ovf   = 1'b0;
            m_ill   = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            m_v    = int'(ifc.free_reg);
            m_pop  = ifc.alloc_req && (m_q.size() > 0);
            m_push = 1'b0;
            if (ifc.free_valid) begin
                if (m_v >= c_PHYS) m_ill = 1'b1;
                else if (m_v != 0) begin
                    if (m_q.size() < c_DEPTH || m_pop) m_push = 1'b1;
                    else m_ovf = 1'b1;
                end
            end
            if (m_pop)  void'(m_q.pop_front());
            if (m_push) m_q.push_back(m_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_ready) begin
            chk("alloc_valid", ifc.alloc_valid, 32'(m_q.size() != 0));
            if (m_q.size() != 0) chk("alloc_reg", ifc.alloc_reg, m_q[0]);
            chk("free_count", ifc.free_count, m_q.size());
            chk("empty", ifc.empty, 32'(m_q.size() == 0));
            chk("full", ifc.full, 32'(m_q.size() == c_DEPTH));
            chk("overflow_err", ifc.overflow_err, 32'(m_ovf));
            chk("illegal_free", ifc.illegal_free, 32'(m_ill));
        end
    end

    task automatic cyc(input logic req, input logic fv, input int r);
        ifc.alloc_req  = req;
        ifc.free_valid = fv;
        ifc.free_reg   = c_W'(r);
        @(posedge clock);
        #1;
    endtask

    // Reset is asserted with an alloc and a free in flight to prove it wins.
    task automatic do_reset();
        reset = 1'b0;
        ifc.alloc_req  = 1'b1;
        ifc.free_valid = 1'b1;
        ifc.free_reg   = c_W'(40);
        @(posedge clock);
        #1;
        reset = 1'b1;
        ifc.alloc_req  = 1'b0;
        ifc.free_valid = 1'b0;
    endtask

    int exp_q[$];
    int v;
    int req_pct;

    initial begin
        ifc.alloc_req  = 1'b0;
        ifc.free_valid = 1'b0;
        ifc.free_reg   = '0;
        @(posedge clock);
        #1;
        do_reset();

        // Reset state and sequential drain
        chk("rst_full", ifc.full, 1);
        chk("rst_empty", ifc.empty, 0);
        chk("rst_count", ifc.free_count, 96);
        for (int i = 0; i < c_DEPTH; i++) begin
            chk("drain_order", ifc.alloc_reg, 32 + i);
            cyc(1, 0, 0);
        end
        chk("drained_empty", ifc.empty, 1);
        chk("drained_valid", ifc.alloc_valid, 0);
        cyc(1, 0, 0);
        chk("req_on_empty_count", ifc.free_count, 0);
        chk("req_on_empty_ovf", ifc.overflow_err, 0);

        // Push into empty, no same-cycle bypass
        cyc(1, 1, 45);
        chk("push45_count", ifc.free_count, 1);
        chk("push45_head", ifc.alloc_reg, 45);
        cyc(0, 1, 77);
        chk("push77_count", ifc.free_count, 2);
        cyc(1, 0, 0);
        chk("pop45_count", ifc.free_count, 1);
        chk("pop45_head", ifc.alloc_reg, 77);
        cyc(1, 0, 0);
        chk("pop77_count", ifc.free_count, 0);

        // Full: push without pop overflows, push with pop is accepted
        do_reset();
        cyc(0, 1, 50);
        chk("ovf_flag", ifc.overflow_err, 1);
        chk("ovf_count", ifc.free_count, 96);
        chk("ovf_head", ifc.alloc_reg, 32);
        cyc(1, 1, 50);
        chk("fullpp_count", ifc.free_count, 96);
        chk("fullpp_head", ifc.alloc_reg, 33);
        for (int i = 0; i < 95; i++) cyc(1, 0, 0);
        chk("fullpp_tail", ifc.alloc_reg, 50);
        chk("ovf_sticky", ifc.overflow_err, 1);

        // Pointer wrap: refill the low slots, then drain across the wrap
        do_reset();
        for (int i = 0; i < 64; i++) cyc(1, 0, 0);
        exp_q.delete();
        for (int i = 32 + 64; i < 128; i++) exp_q.push_back(i);
        for (int i = 100; i <= 195; i++) begin
            v = i % 128;
            if (v >= 32) begin
                cyc(0, 1, v);
                exp_q.push_back(v);
            end
        end
        chk("wrap_full", ifc.full, 1);
        for (int i = 0; i < c_DEPTH; i++) begin
            chk("wrap_order", ifc.alloc_reg, exp_q[i]);
            cyc(1, 0, 0);
        end
        chk("wrap_empty", ifc.empty, 1);

        // Index 0 ignored, out-of-range index flagged
        cyc(0, 1, 0);
        chk("zero_count", ifc.free_count, 0);
        chk("zero_ill", ifc.illegal_free, 0);
        chk("zero_ovf", ifc.overflow_err, 0);
        cyc(0, 1, 130);
        chk("ill_flag", ifc.illegal_free, 1);
        chk("ill_count", ifc.free_count, 0);

        // Reset mid-stream with traffic active
        do_reset();
        for (int i = 0; i < 86; i++) cyc(1, 0, 0);
        cyc(0, 1, 200);
        chk("mid_count", ifc.free_count, 10);
        cyc(1, 1, 60);
        do_reset();
        chk("midrst_count", ifc.free_count, 96);
        chk("midrst_head", ifc.alloc_reg, 32);
        chk("midrst_ill", ifc.illegal_free, 0);
        chk("midrst_ovf", ifc.overflow_err, 0);

        // Randomised traffic with varying allocation pressure
        for (int ph = 0; ph < 6; ph++) begin
            case (ph % 3)
                0:       req_pct = 80;
                1:       req_pct = 25;
                default: req_pct = 50;
            endcase
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(299) == 0) begin
                    do_reset();
                end else begin
                    case ($urandom_range(31))
                        0:       v = 0;
                        1:       v = 128 + $urandom_range(127);
                        default: v = 32 + $urandom_range(95);
                    endcase
                    cyc($urandom_range(99) < req_pct, $urandom_range(99) < 50, v);
                end
            end
        end

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
